// File: rtl/start_capture_pkg.sv
// -----------------------------------------------------------------------------
// start_capture_pkg
// Shared types and constants for the start_capture front-end stage.
//   state_e  : controller states (idle, launch pulse, run, result held)
//   DROP_W   : width of the rejected-press counter
//   DROP_MAX : saturation value of the rejected-press counter
//   sat_inc  : saturating increment used for the rejected-press counter
// -----------------------------------------------------------------------------
package start_capture_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_DONE   = 2'd3
  } state_e;

  localparam int              DROP_W   = 4;
  localparam logic [DROP_W-1:0] DROP_MAX = 4'd15;

  // Increment that sticks at DROP_MAX instead of wrapping back to zero.
  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (v == DROP_MAX) ? v : v + DROP_W'(1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// Synchronizes the raw active-low push-button into the clk domain and filters
// contact bounce. The debounced level only changes after the synchronized key
// has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   key_n      : raw button, 0 = pressed, asynchronous to clk
//   pressed    : debounced level, 1 while the button is held
//   press_edge : one-cycle pulse on a debounced released->pressed transition
// SYNC_STAGES must be at least 2.
// -----------------------------------------------------------------------------
module key_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic pressed,
  output logic press_edge
);

  // The counter never needs to hold more than DEBOUNCE_CYCLES-1.
  localparam int               CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] key_sync_q, key_sync_d;
  logic                   key_level_q, key_level_d;   // debounced key_n, 1 = released
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   press_edge_q, press_edge_d;
  logic                   key_synced;

  assign key_synced = key_sync_q[SYNC_STAGES-1];

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    key_sync_d  = {key_sync_q[SYNC_STAGES-2:0], key_n};
    key_level_d = key_level_q;
    cnt_d       = '0;
    if (key_synced != key_level_q) begin
      if (cnt_q == CNT_LAST) begin
        key_level_d = key_synced;              // stable long enough: accept, counter clears
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    // Only the released->pressed direction is of interest downstream.
    press_edge_d = key_level_q & ~key_level_d;
  end

  // NOTE: synchronizer flops are reset like any other state so the key reads
  // "released" right after reset instead of an unknown that could fake a press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      key_sync_q   <= '1;
      key_level_q  <= 1'b1;
      cnt_q        <= '0;
      press_edge_q <= 1'b0;
    end else begin
      key_sync_q   <= key_sync_d;
      key_level_q  <= key_level_d;
      cnt_q        <= cnt_d;
      press_edge_q <= press_edge_d;
    end
  end

  assign pressed    = ~key_level_q;
  assign press_edge = press_edge_q;

endmodule

// File: rtl/start_capture.sv
// -----------------------------------------------------------------------------
// start_capture
// Front end for the bit-counting control/datapath pair. Debounces the start
// button, synchronizes the switch operand, captures it on a clean press while
// the counter is ready, issues a one-cycle start pulse and tracks the run
// until done, holding the operand stable throughout.
//   clk          : system clock (CLOCK_50)
//   reset        : asynchronous, active-low reset
//   key_n        : raw push-button, 0 = pressed
//   sw_in        : raw switch operand
//   ready        : counter idle, can accept start
//   done         : counter finished the current operand
//   start        : one-cycle launch pulse
//   operand      : captured operand, changes only when a launch begins
//   busy         : high from launch until done is observed
//   result_valid : high from done until the next accepted press
//   dropped      : saturating count of rejected presses
// All outputs are registered.
// -----------------------------------------------------------------------------
module start_capture
  import start_capture_pkg::*;
#(
  parameter int DATA_W          = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_n,
  input  logic [DATA_W-1:0] sw_in,
  input  logic              ready,
  input  logic              done,
  output logic              start,
  output logic [DATA_W-1:0] operand,
  output logic              busy,
  output logic              result_valid,
  output logic [DROP_W-1:0] dropped
);

  logic key_pressed;
  logic press_edge;
  logic press;

  key_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk        (clk),
    .reset      (reset),
    .key_n      (key_n),
    .pressed    (key_pressed),
    .press_edge (press_edge)
  );

  // The edge pulse is only honoured while the debounced level agrees it is held.
  assign press = press_edge & key_pressed;

  // Switch synchronizer: capture always reads the last stage, never sw_in.
  logic [SYNC_STAGES-1:0][DATA_W-1:0] sw_sync_q, sw_sync_d;
  logic [DATA_W-1:0]                  sw_synced;

  assign sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], sw_in};
  assign sw_synced = sw_sync_q[SYNC_STAGES-1];

  state_e            state_q, state_d;
  logic [DATA_W-1:0] operand_q, operand_d;
  logic [DROP_W-1:0] dropped_q, dropped_d;
  logic              start_q, start_d;
  logic              busy_q, busy_d;
  logic              result_valid_q, result_valid_d;

  always_comb begin
    state_d   = state_q;
    operand_d = operand_q;
    dropped_d = dropped_q;

    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (press) begin
          if (ready) begin
            operand_d = sw_synced;
            state_d   = S_LAUNCH;
          end else begin
            dropped_d = sat_inc(dropped_q);
          end
        end
      end
      S_LAUNCH: state_d = S_RUN;
      S_RUN: begin
        // A press here is never queued; done still wins in the same cycle.
        if (press) dropped_d = sat_inc(dropped_q);
        if (done)  state_d   = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs decode the next state so they line up with state_q after the edge.
    start_d        = (state_d == S_LAUNCH);
    busy_d         = (state_d == S_LAUNCH) || (state_d == S_RUN);
    result_valid_d = (state_d == S_DONE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sw_sync_q      <= '0;
      state_q        <= S_IDLE;
      operand_q      <= '0;
      dropped_q      <= '0;
      start_q        <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      sw_sync_q      <= sw_sync_d;
      state_q        <= state_d;
      operand_q      <= operand_d;
      dropped_q      <= dropped_d;
      start_q        <= start_d;
      busy_q         <= busy_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign start        = start_q;
  assign operand      = operand_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_start_capture.sv
// -----------------------------------------------------------------------------
// tb_start_capture
// Self-checking bench for start_capture: a table of stimulus phases with
// expected end-of-phase results, hand-written corner sequences, and a random
// run, all compared every cycle against a behavioural model.
// -----------------------------------------------------------------------------
module tb_start_capture;

  localparam int DATA_W = 8;
  localparam int SYNC   = 2;
  localparam int DEB    = 16;

  logic              clk   = 1'b0;
  logic              reset = 1'b0;
  logic              key_n = 1'b1;
  logic [DATA_W-1:0] sw_in = '0;
  logic              ready = 1'b0;
  logic              done  = 1'b0;
  logic              start;
  logic [DATA_W-1:0] operand;
  logic              busy;
  logic              result_valid;
  logic [3:0]        dropped;

  always #5 clk = ~clk;

  start_capture #(
    .DATA_W          (DATA_W),
    .SYNC_STAGES     (SYNC),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .key_n        (key_n),
    .sw_in        (sw_in),
    .ready        (ready),
    .done         (done),
    .start        (start),
    .operand      (operand),
    .busy         (busy),
    .result_valid (result_valid),
    .dropped      (dropped)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Synchronizers are delay queues, the debouncer is a
  // disagreement run-length, and the controller is tracked as three flags:
  // "launching", "busy" and "result held".
  // ---------------------------------------------------------------------------
  logic              mq_key[$];
  logic [DATA_W-1:0] mq_sw[$];
  logic              m_level;     // debounced key_n
  int                m_run;       // consecutive disagreeing cycles
  logic              m_edge;      // press edge presented to the controller next cycle
  logic              m_start, m_busy, m_rv;
  logic [DATA_W-1:0] m_op;
  int                m_drop;
  logic              prev_start  = 1'b0;
  int                start_count = 0;

  function automatic void m_reset();
    mq_key = {};
    mq_sw  = {};
    for (int i = 0; i < SYNC; i++) begin
      mq_key.push_back(1'b1);
      mq_sw.push_back('0);
    end
    m_level = 1'b1;
    m_run   = 0;
    m_edge  = 1'b0;
    m_start = 1'b0;
    m_busy  = 1'b0;
    m_rv    = 1'b0;
    m_op    = '0;
    m_drop  = 0;
  endfunction

  function automatic void m_step();
    logic              old_key;
    logic [DATA_W-1:0] old_sw;
    logic              old_level;
    logic              edge_seen;
    old_key   = mq_key[0];
    old_sw    = mq_sw[0];
    old_level = m_level;
    edge_seen = m_edge;
    mq_key.push_back(key_n);
    void'(mq_key.pop_front());
    mq_sw.push_back(sw_in);
    void'(mq_sw.pop_front());

    if (old_key != m_level) begin
      if (m_run == DEB - 1) begin
        m_level = old_key;
        m_run   = 0;
      end else begin
        m_run++;
      end
    end else begin
      m_run = 0;
    end
    m_edge = old_level && !m_level;

    if (m_start) begin
      m_start = 1'b0;                       // launch lasts one cycle, run continues
    end else if (m_busy) begin
      if (edge_seen) m_drop = (m_drop < 15) ? m_drop + 1 : 15;
      if (done) begin
        m_busy = 1'b0;
        m_rv   = 1'b1;
      end
    end else if (edge_seen) begin
      if (ready) begin
        m_start = 1'b1;
        m_busy  = 1'b1;
        m_rv    = 1'b0;
        m_op    = old_sw;
      end else begin
        m_drop = (m_drop < 15) ? m_drop + 1 : 15;
      end
    end
  endfunction

  // One clock: advance the model with the inputs the DUT samples, then
  // compare all outputs 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    if (!reset) m_reset();
    else        m_step();
    #1;
    if (start) start_count++;
    check("start",        start,        m_start);
    check("busy",         busy,         m_busy);
    check("result_valid", result_valid, m_rv);
    check("operand",      operand,      m_op);
    check("dropped",      dropped,      m_drop);
    check("start_spacing", start & prev_start, 0);
    prev_start = start;
  endtask

  task automatic hold(input int n, input logic k, input logic [DATA_W-1:0] s,
                      input logic r, input logic d);
    for (int c = 0; c < n; c++) begin
      key_n = k; sw_in = s; ready = r; done = d;
      tick();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus table: each row is a phase; expectations hold at its end.
  // ---------------------------------------------------------------------------
  typedef struct {
    string             name;
    int                cycles;
    int                bounce;     // toggle key_n every N cycles (0 = steady)
    logic              key_n;
    logic [DATA_W-1:0] sw;
    logic              ready;
    logic              done;
    int                exp_starts;
    logic [DATA_W-1:0] exp_op;
    logic              exp_busy;
    logic              exp_rv;
    int                exp_drop;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(input string name, input int cycles, input int bounce,
                                  input logic k, input logic [DATA_W-1:0] s, input logic r,
                                  input logic d, input int es, input logic [DATA_W-1:0] eo,
                                  input logic eb, input logic erv, input int ed);
    vec_t v;
    v.name = name; v.cycles = cycles; v.bounce = bounce; v.key_n = k; v.sw = s;
    v.ready = r; v.done = d; v.exp_starts = es; v.exp_op = eo; v.exp_busy = eb;
    v.exp_rv = erv; v.exp_drop = ed;
    vecs.push_back(v);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t limit=2000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int drop_before;
    bit found;

    //        name         cyc bnc key sw     rdy dn  st op     bsy rv drop
    add_vec("bounce",      60, 5, 0, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0);
    add_vec("settle",      20, 0, 1, 8'h00, 1, 0,  0, 8'h00, 0, 0, 0);
    add_vec("press_a5",    40, 0, 0, 8'hA5, 1, 0,  1, 8'hA5, 1, 0, 0);
    add_vec("release_a5",  30, 0, 1, 8'hA5, 1, 0,  0, 8'hA5, 1, 0, 0);
    add_vec("done_a5",      1, 0, 1, 8'h3C, 1, 1,  0, 8'hA5, 0, 1, 0);
    for (int p = 1; p <= 3; p++) begin
      add_vec($sformatf("nrdy_press%0d", p), 25, 0, 0, 8'h33, 0, 0, 0, 8'hA5, 0, 1, p);
      add_vec($sformatf("nrdy_rel%0d", p),   25, 0, 1, 8'h33, 0, 0, 0, 8'hA5, 0, 1, p);
    end
    add_vec("press_0f",    25, 0, 0, 8'h0F, 1, 0,  1, 8'h0F, 1, 0, 3);
    add_vec("release_0f",  25, 0, 1, 8'h0F, 1, 0,  0, 8'h0F, 1, 0, 3);
    add_vec("done_0f",      1, 0, 1, 8'h0F, 1, 1,  0, 8'h0F, 0, 1, 3);

    // Reset state.
    m_reset();
    repeat (3) tick();
    check("reset.start",   start,        0);
    check("reset.operand", operand,      0);
    check("reset.busy",    busy,         0);
    check("reset.rv",      result_valid, 0);
    check("reset.dropped", dropped,      0);
    reset = 1'b1;

    // Table phases.
    foreach (vecs[i]) begin
      start_count = 0;
      for (int c = 0; c < vecs[i].cycles; c++) begin
        if (vecs[i].bounce > 0 && ((c / vecs[i].bounce) % 2) == 1) key_n = ~vecs[i].key_n;
        else                                                       key_n = vecs[i].key_n;
        sw_in = vecs[i].sw;
        ready = vecs[i].ready;
        done  = vecs[i].done;
        tick();
      end
      check({vecs[i].name, ".starts"},  start_count,  vecs[i].exp_starts);
      check({vecs[i].name, ".operand"}, operand,      vecs[i].exp_op);
      check({vecs[i].name, ".busy"},    busy,         vecs[i].exp_busy);
      check({vecs[i].name, ".rv"},      result_valid, vecs[i].exp_rv);
      check({vecs[i].name, ".dropped"}, dropped,      vecs[i].exp_drop);
    end

    // Press edge and done arrive together while running.
    start_count = 0;
    hold(25, 1'b0, 8'h55, 1'b1, 1'b0);
    hold(25, 1'b1, 8'h55, 1'b1, 1'b0);
    check("t4.launch", start_count, 1);
    start_count = 0;
    drop_before = m_drop;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      key_n = 1'b0; sw_in = 8'h66; ready = 1'b1;
      done  = m_edge;                        // edge reaches the controller this cycle
      tick();
      found = done;
    end
    check("t4.edge_found", found, 1);
    check("t4.rv",         result_valid, 1);
    check("t4.busy",       busy, 0);
    check("t4.dropped",    dropped, drop_before + 1);
    hold(10, 1'b0, 8'h66, 1'b1, 1'b0);
    hold(25, 1'b1, 8'h66, 1'b1, 1'b0);
    check("t4.no_restart", start_count, 0);
    check("t4.operand",    operand, 8'h55);

    // Twenty rejected presses saturate the counter.
    for (int p = 0; p < 20; p++) begin
      hold(25, 1'b0, 8'h11, 1'b0, 1'b0);
      hold(25, 1'b1, 8'h11, 1'b0, 1'b0);
      if (p == 10) check("t5.dropped_at11", dropped, 15);
    end
    check("t5.dropped_sat", dropped, 15);

    // Asynchronous reset in the middle of a run.
    start_count = 0;
    hold(25, 1'b0, 8'hFF, 1'b1, 1'b0);
    hold(10, 1'b1, 8'hFF, 1'b1, 1'b0);
    check("t6.launch",  start_count, 1);
    check("t6.operand", operand, 8'hFF);
    check("t6.busy",    busy, 1);
    #2;
    reset = 1'b0;
    #1;
    check("t6.async.start",   start,        0);
    check("t6.async.operand", operand,      0);
    check("t6.async.busy",    busy,         0);
    check("t6.async.rv",      result_valid, 0);
    check("t6.async.dropped", dropped,      0);
    m_reset();
    prev_start = 1'b0;
    tick();
    reset = 1'b1;
    start_count = 0;
    hold(30, 1'b1, 8'hFF, 1'b1, 1'b0);
    check("t6.no_start_after_release", start_count, 0);
    hold(25, 1'b0, 8'h77, 1'b1, 1'b0);
    check("t6.new_press",   start_count, 1);
    check("t6.new_operand", operand, 8'h77);

    // Random run against the model.
    for (int seg = 0; seg < 150; seg++) begin
      int               len;
      logic             k;
      logic             r;
      logic [DATA_W-1:0] s;
      len = $urandom_range(30, 1);
      k   = $urandom_range(1, 0);
      r   = ($urandom_range(3, 0) != 0);
      s   = DATA_W'($urandom);
      for (int c = 0; c < len; c++) begin
        key_n = k; sw_in = s; ready = r;
        done  = ($urandom_range(7, 0) == 0);
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
